// File: rtl/sdram_port_responder.sv
// Responder end of the custom-logic SDRAM port: on-chip word array with a fixed
// read-latency return pipeline, sticky error flags and saturating request counters.
`timescale 1ns/1ps
module sdram_port_responder #(
  parameter int          ADDR_BITS    = 12,
  parameter int          READ_LATENCY = 2,
  parameter logic [25:0] BASE_ADDR    = 26'd0
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        sdram_read_en,
  input  logic        sdram_write_en,
  input  logic [25:0] address_sdram,
  input  logic [31:0] writeData_sdram,
  input  logic        clear_stats,
  output logic [31:0] data_sdram,
  output logic        sdram_datareadvalid,
  output logic        range_error,
  output logic        collision_error,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  logic [31:0] mem [DEPTH];

  logic [25:0]          offset;
  logic [ADDR_BITS-1:0] index;
  logic                 in_range;
  logic                 read_accept;
  logic                 collision;

  // Offset wraps modulo 2**26, so addresses below BASE_ADDR land far out of range.
  assign offset      = address_sdram - BASE_ADDR;
  assign in_range    = ({6'd0, offset} < DEPTH_W);
  assign index       = offset[ADDR_BITS-1:0];
  assign collision   = sdram_read_en & sdram_write_en;
  assign read_accept = sdram_read_en & ~sdram_write_en;

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (sdram_write_en && in_range) begin
      mem[index] <= writeData_sdram;
    end
  end

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [31:0]             pipe_data [READ_LATENCY];

  // Each stage only loads data alongside a valid beat, so the final stage holds
  // the last returned word between beats.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_data[i]  <= 32'd0;
      end
    end else begin
      pipe_valid[0] <= read_accept;
      if (read_accept) begin
        pipe_data[0] <= in_range ? mem[index] : OOR_DATA;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
        end
      end
    end
  end

  assign sdram_datareadvalid = pipe_valid[READ_LATENCY-1];
  assign data_sdram          = pipe_data[READ_LATENCY-1];

  // clear_stats takes priority over any increment or flag set in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      read_count      <= 16'd0;
      write_count     <= 16'd0;
      range_error     <= 1'b0;
      collision_error <= 1'b0;
    end else if (clear_stats) begin
      read_count      <= 16'd0;
      write_count     <= 16'd0;
      range_error     <= 1'b0;
      collision_error <= 1'b0;
    end else begin
      if (read_accept && read_count != 16'hFFFF) begin
        read_count <= read_count + 16'd1;
      end
      if (sdram_write_en && write_count != 16'hFFFF) begin
        write_count <= write_count + 16'd1;
      end
      if ((sdram_read_en || sdram_write_en) && !in_range) begin
        range_error <= 1'b1;
      end
      if (collision) begin
        collision_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_responder.sv
// Directed bench for sdram_port_responder: read latency, ordering, range/collision
// flags, reset flush and counter saturation/clear.
`timescale 1ns/1ps
module tb_sdram_port_responder;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [25:0] addr = 26'd0;
  logic [31:0] wdata = 32'd0;
  logic        clear = 1'b0;
  logic [31:0] data_sdram;
  logic        valid;
  logic        range_error;
  logic        collision_error;
  logic [15:0] read_count;
  logic [15:0] write_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdram_port_responder #(
    .ADDR_BITS(12),
    .READ_LATENCY(2),
    .BASE_ADDR(26'd0)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .sdram_read_en(read_en),
    .sdram_write_en(write_en),
    .address_sdram(addr),
    .writeData_sdram(wdata),
    .clear_stats(clear),
    .data_sdram(data_sdram),
    .sdram_datareadvalid(valid),
    .range_error(range_error),
    .collision_error(collision_error),
    .read_count(read_count),
    .write_count(write_count)
  );

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic drive(input logic re, input logic we, input logic [25:0] a,
                       input logic [31:0] d, input logic clr);
    @(negedge clk);
    read_en = re; write_en = we; addr = a; wdata = d; clear = clr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (data_sdram !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", data_sdram); end
    checks++; if (range_error !== 1'b0 || collision_error !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", range_error, collision_error); end
    checks++; if (read_count !== 16'd0 || write_count !== 16'd0) begin errors++; $display("FAIL reset_counts got %h/%h exp 0/0", read_count, write_count); end
    @(negedge clk); n_rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_read_after_write();
    drive(1'b0, 1'b1, 26'd5, 32'hA5A5_0001, 1'b0);
    drive(1'b1, 1'b0, 26'd5, 32'd0, 1'b0);
    idle();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL raw_early_valid got %b exp 0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL raw_valid got %b exp 1", valid); end
    checks++; if (data_sdram !== 32'hA5A5_0001) begin errors++; $display("FAIL raw_data got %h exp a5a50001", data_sdram); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL raw_pulse got %b exp 0", valid); end
    checks++; if (data_sdram !== 32'hA5A5_0001) begin errors++; $display("FAIL raw_hold got %h exp a5a50001", data_sdram); end
    checks++; if (write_count !== 16'd1 || read_count !== 16'd1) begin errors++; $display("FAIL raw_counts got %0d/%0d exp 1/1", write_count, read_count); end
    $display("test_read_after_write done");
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 26'(i), 32'(i * 3), 1'b0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 9) begin
        checks++; if (valid !== 1'b1 || data_sdram !== 32'((c - 2) * 3)) begin
          errors++; $display("FAIL b2b_beat%0d got %b/%h exp 1/%h", c - 2, valid, data_sdram, 32'((c - 2) * 3));
        end
      end else begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d got %b exp 0", c, valid); end
      end
      read_en = (c < 8); write_en = 1'b0; addr = 26'(c); wdata = 32'd0;
    end
    checks++; if (read_count !== 16'd8 || write_count !== 16'd8) begin errors++; $display("FAIL b2b_counts got %0d/%0d exp 8/8", read_count, write_count); end
    $display("test_back_to_back done");
  endtask

  task automatic test_range();
    drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    idle();
    checks++; if (range_error !== 1'b0) begin errors++; $display("FAIL range_cleared got %b exp 0", range_error); end
    drive(1'b1, 1'b0, 26'd4096, 32'd0, 1'b0);
    idle();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || data_sdram !== 32'hDEAD_BEEF) begin errors++; $display("FAIL range_read got %b/%h exp 1/deadbeef", valid, data_sdram); end
    checks++; if (range_error !== 1'b1) begin errors++; $display("FAIL range_flag got %b exp 1", range_error); end
    drive(1'b0, 1'b1, 26'd4096, 32'h0000_FFFF, 1'b0);
    drive(1'b0, 1'b1, 26'd4095, 32'h0FFF_0FFF, 1'b0);
    drive(1'b1, 1'b0, 26'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 26'd4095, 32'd0, 1'b0);
    idle();
    checks++; if (valid !== 1'b1 || data_sdram !== 32'd0) begin errors++; $display("FAIL range_idx0 got %b/%h exp 1/0", valid, data_sdram); end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || data_sdram !== 32'h0FFF_0FFF) begin errors++; $display("FAIL range_last got %b/%h exp 1/0fff0fff", valid, data_sdram); end
    $display("test_range done");
  endtask

  task automatic test_collision();
    drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    drive(1'b1, 1'b1, 26'd9, 32'h0000_1234, 1'b0);
    idle();
    checks++; if (collision_error !== 1'b1) begin errors++; $display("FAIL coll_flag got %b exp 1", collision_error); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL coll_no_beat got %b exp 0", valid); end
    checks++; if (read_count !== 16'd0 || write_count !== 16'd1) begin errors++; $display("FAIL coll_counts got %0d/%0d exp 0/1", read_count, write_count); end
    drive(1'b1, 1'b0, 26'd9, 32'd0, 1'b0);
    idle();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || data_sdram !== 32'h0000_1234) begin errors++; $display("FAIL coll_readback got %b/%h exp 1/00001234", valid, data_sdram); end
    checks++; if (read_count !== 16'd1) begin errors++; $display("FAIL coll_rcount got %0d exp 1", read_count); end
    $display("test_collision done");
  endtask

  task automatic test_reset_flush();
    drive(1'b0, 1'b1, 26'd20, 32'hCAFE_0020, 1'b0);
    drive(1'b1, 1'b0, 26'd20, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 26'd20, 32'd0, 1'b0);
    @(negedge clk);
    read_en = 1'b0; n_rst = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || data_sdram !== 32'd0) begin errors++; $display("FAIL flush_outputs got %b/%h exp 0/0", valid, data_sdram); end
    checks++; if (read_count !== 16'd0 || write_count !== 16'd0 || collision_error !== 1'b0) begin
      errors++; $display("FAIL flush_stats got %0d/%0d/%b exp 0/0/0", read_count, write_count, collision_error);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_ghost%0d got %b exp 0", c, valid); end
    end
    drive(1'b1, 1'b0, 26'd20, 32'd0, 1'b0);
    idle();
    @(negedge clk);
    checks++; if (valid !== 1'b1 || data_sdram !== 32'hCAFE_0020) begin errors++; $display("FAIL flush_array got %b/%h exp 1/cafe0020", valid, data_sdram); end
    $display("test_reset_flush done");
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 26'd0, 32'd0, 1'b1);
    repeat (65535) drive(1'b0, 1'b1, 26'd100, 32'd7, 1'b0);
    idle();
    checks++; if (write_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", write_count); end
    drive(1'b0, 1'b1, 26'd100, 32'd7, 1'b0);
    idle();
    checks++; if (write_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", write_count); end
    drive(1'b1, 1'b1, 26'd4096, 32'd0, 1'b0);
    idle();
    checks++; if (range_error !== 1'b1 || collision_error !== 1'b1) begin errors++; $display("FAIL sat_flags_set got %b%b exp 11", range_error, collision_error); end
    drive(1'b0, 1'b1, 26'd4096, 32'd0, 1'b1);
    idle();
    checks++; if (write_count !== 16'd0 || read_count !== 16'd0) begin errors++; $display("FAIL clear_counts got %h/%h exp 0/0", write_count, read_count); end
    checks++; if (range_error !== 1'b0 || collision_error !== 1'b0) begin errors++; $display("FAIL clear_flags got %b%b exp 00", range_error, collision_error); end
    $display("test_saturation done");
  endtask

  initial begin
    test_reset();
    test_read_after_write();
    test_back_to_back();
    test_range();
    test_collision();
    test_reset_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
